// File: rtl/udma_hyper_reg_if_multi.sv
// udma_hyper_reg_if_multi: per-channel hyperbus register banks feeding a shared descriptor FIFO
//   clk_i/rst_i       : clock, synchronous active-high reset
//   cfg_*             : register bus, upper CW address bits select the channel, low 5 bits the word offset
//   busy_i            : hyper controller activity, reported in STATUS
//   trans_*           : head descriptor of the FIFO with valid/ready handshake
//   HYPER_REG_IF_TWD_EN : when defined, adds the per-channel 2D registers and carries them in descriptors
module udma_hyper_reg_if_multi #(
  parameter int NB_CH = 2,
  parameter int L2_AWIDTH_NOAL = 12,
  parameter int TRANS_SIZE = 16,
  parameter int QUEUE_DEPTH = 4,
  localparam int CW = (NB_CH > 1) ? $clog2(NB_CH) : 1
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [31:0]               cfg_data_i,
  input  logic [4+CW:0]             cfg_addr_i,
  input  logic                      cfg_valid_i,
  input  logic                      cfg_reg_rwn_i,
  output logic [31:0]               cfg_data_o,
  output logic                      cfg_ready_o,
  input  logic                      busy_i,
  output logic                      trans_valid_o,
  input  logic                      trans_ready_i,
  output logic [CW-1:0]             trans_ch_o,
  output logic                      trans_rx_o,
  output logic [L2_AWIDTH_NOAL-1:0] trans_l2_addr_o,
  output logic [TRANS_SIZE-1:0]     trans_size_o,
  output logic [31:0]               trans_hyper_addr_o,
  output logic                      trans_rw_o,
  output logic                      trans_addr_space_o,
  output logic                      trans_burst_type_o,
  output logic                      trans_twd_ext_act_o,
  output logic                      trans_twd_l2_act_o,
  output logic [TRANS_SIZE-1:0]     trans_twd_ext_count_o,
  output logic [TRANS_SIZE-1:0]     trans_twd_ext_stride_o,
  output logic [TRANS_SIZE-1:0]     trans_twd_l2_count_o,
  output logic [TRANS_SIZE-1:0]     trans_twd_l2_stride_o
);
  localparam int AW = $clog2(QUEUE_DEPTH);
  typedef struct packed {
    logic [CW-1:0]             ch;
    logic                      rx;
    logic [L2_AWIDTH_NOAL-1:0] l2;
    logic [TRANS_SIZE-1:0]     size;
    logic [31:0]               haddr;
    logic                      rw;
    logic                      addr_space;
    logic                      burst;
`ifdef HYPER_REG_IF_TWD_EN
    logic                      ext_act;
    logic [TRANS_SIZE-1:0]     ext_cnt;
    logic [TRANS_SIZE-1:0]     ext_str;
    logic                      l2_act;
    logic [TRANS_SIZE-1:0]     l2_cnt;
    logic [TRANS_SIZE-1:0]     l2_str;
`endif
  } desc_t;
  logic [L2_AWIDTH_NOAL-1:0] r_rx_saddr [NB_CH];
  logic [L2_AWIDTH_NOAL-1:0] r_tx_saddr [NB_CH];
  logic [TRANS_SIZE-1:0]     r_rx_size  [NB_CH];
  logic [TRANS_SIZE-1:0]     r_tx_size  [NB_CH];
  logic [31:0]               r_haddr    [NB_CH];
  logic [31:0]               r_hcfg     [NB_CH];
  logic [NB_CH-1:0]          r_rx_cont, r_tx_cont, r_rw, r_as, r_burst, r_ovf;
`ifdef HYPER_REG_IF_TWD_EN
  logic [NB_CH-1:0]          r_ext_act, r_l2_act;
  logic [TRANS_SIZE-1:0]     r_ext_cnt [NB_CH];
  logic [TRANS_SIZE-1:0]     r_ext_str [NB_CH];
  logic [TRANS_SIZE-1:0]     r_l2_cnt  [NB_CH];
  logic [TRANS_SIZE-1:0]     r_l2_str  [NB_CH];
`endif
  desc_t                     r_q [QUEUE_DEPTH];
  logic [AW-1:0]             r_rd, r_wr;
  logic [AW:0]               r_cnt;
  logic [CW-1:0]             w_ch;
  logic [4:0]                w_off;
  logic                      w_wr, w_rd, w_enq_req, w_full, w_deq, w_enq;
  logic [NB_CH-1:0]          w_pend_rx, w_pend_tx;
  logic [AW-1:0]             w_idx;
  desc_t                     w_new, w_head;
  assign w_ch      = cfg_addr_i[4+CW:5];
  assign w_off     = cfg_addr_i[4:0];
  assign w_wr      = cfg_valid_i & ~cfg_reg_rwn_i & (int'(w_ch) < NB_CH);
  assign w_rd      = cfg_valid_i &  cfg_reg_rwn_i & (int'(w_ch) < NB_CH);
  assign w_enq_req = w_wr & ((w_off == 5'd2) | (w_off == 5'd5)) & cfg_data_i[4];
  assign w_full    = r_cnt == (AW+1)'(QUEUE_DEPTH);
  assign w_deq     = (r_cnt != '0) & trans_ready_i;
  // a dequeue in the same cycle frees the slot the new entry lands in
  assign w_enq     = w_enq_req & (~w_full | w_deq);
  assign w_head    = r_q[r_rd];
  assign cfg_ready_o = 1'b1;
  // snapshot is taken from the register values before this cycle's write lands
  always_comb begin
    w_new            = '0;
    w_new.ch         = w_ch;
    w_new.rx         = w_off == 5'd2;
    w_new.l2         = w_new.rx ? r_rx_saddr[w_ch] : r_tx_saddr[w_ch];
    w_new.size       = w_new.rx ? r_rx_size[w_ch] : r_tx_size[w_ch];
    w_new.haddr      = r_haddr[w_ch];
    w_new.rw         = r_rw[w_ch];
    w_new.addr_space = r_as[w_ch];
    w_new.burst      = r_burst[w_ch];
`ifdef HYPER_REG_IF_TWD_EN
    w_new.ext_act    = r_ext_act[w_ch];
    w_new.ext_cnt    = r_ext_cnt[w_ch];
    w_new.ext_str    = r_ext_str[w_ch];
    w_new.l2_act     = r_l2_act[w_ch];
    w_new.l2_cnt     = r_l2_cnt[w_ch];
    w_new.l2_str     = r_l2_str[w_ch];
`endif
  end
  always_comb begin
    w_pend_rx = '0;
    w_pend_tx = '0;
    w_idx     = '0;
    for (int i = 0; i < QUEUE_DEPTH; i++) begin
      w_idx = r_rd + AW'(i);
      if (i < int'(r_cnt))
        for (int c = 0; c < NB_CH; c++)
          if (int'(r_q[w_idx].ch) == c) begin
            if (r_q[w_idx].rx) w_pend_rx[c] = 1'b1;
            else w_pend_tx[c] = 1'b1;
          end
    end
  end
  always_comb begin
    cfg_data_o = '0;
    if (w_rd)
      case (w_off)
        5'd0:  cfg_data_o = 32'(r_rx_saddr[w_ch]);
        5'd1:  cfg_data_o = 32'(r_rx_size[w_ch]);
        5'd2:  cfg_data_o = {26'b0, w_pend_rx[w_ch], 2'b0, 2'b10, r_rx_cont[w_ch]};
        5'd3:  cfg_data_o = 32'(r_tx_saddr[w_ch]);
        5'd4:  cfg_data_o = 32'(r_tx_size[w_ch]);
        5'd5:  cfg_data_o = {26'b0, w_pend_tx[w_ch], 2'b0, 2'b10, r_tx_cont[w_ch]};
        5'd6:  cfg_data_o = {29'b0, r_rw[w_ch], r_as[w_ch], r_burst[w_ch]};
        5'd7:  cfg_data_o = r_haddr[w_ch];
        5'd8:  cfg_data_o = r_hcfg[w_ch];
        5'd9:  cfg_data_o = {16'b0, 8'(r_cnt), 6'b0, r_ovf[w_ch], busy_i};
`ifdef HYPER_REG_IF_TWD_EN
        5'd10: cfg_data_o = {31'b0, r_ext_act[w_ch]};
        5'd11: cfg_data_o = 32'(r_ext_cnt[w_ch]);
        5'd12: cfg_data_o = 32'(r_ext_str[w_ch]);
        5'd13: cfg_data_o = {31'b0, r_l2_act[w_ch]};
        5'd14: cfg_data_o = 32'(r_l2_cnt[w_ch]);
        5'd15: cfg_data_o = 32'(r_l2_str[w_ch]);
`endif
        default: cfg_data_o = '0;
      endcase
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int c = 0; c < NB_CH; c++) begin
        r_rx_saddr[c] <= '0;
        r_tx_saddr[c] <= '0;
        r_rx_size[c]  <= '0;
        r_tx_size[c]  <= '0;
        r_haddr[c]    <= '0;
        r_hcfg[c]     <= '0;
`ifdef HYPER_REG_IF_TWD_EN
        r_ext_cnt[c]  <= '0;
        r_ext_str[c]  <= '0;
        r_l2_cnt[c]   <= '0;
        r_l2_str[c]   <= '0;
`endif
      end
      r_rx_cont <= '0;
      r_tx_cont <= '0;
      r_rw      <= '1;
      r_as      <= '0;
      r_burst   <= '1;
      r_ovf     <= '0;
`ifdef HYPER_REG_IF_TWD_EN
      r_ext_act <= '0;
      r_l2_act  <= '0;
`endif
    end else begin
      if (w_wr)
        case (w_off)
          5'd0:  r_rx_saddr[w_ch] <= cfg_data_i[L2_AWIDTH_NOAL-1:0];
          5'd1:  r_rx_size[w_ch]  <= cfg_data_i[TRANS_SIZE-1:0];
          5'd2:  r_rx_cont[w_ch]  <= cfg_data_i[0];
          5'd3:  r_tx_saddr[w_ch] <= cfg_data_i[L2_AWIDTH_NOAL-1:0];
          5'd4:  r_tx_size[w_ch]  <= cfg_data_i[TRANS_SIZE-1:0];
          5'd5:  r_tx_cont[w_ch]  <= cfg_data_i[0];
          5'd6:  {r_rw[w_ch], r_as[w_ch], r_burst[w_ch]} <= cfg_data_i[2:0];
          5'd7:  r_haddr[w_ch]    <= cfg_data_i;
          5'd8:  r_hcfg[w_ch]     <= cfg_data_i;
          5'd9:  if (cfg_data_i[1]) r_ovf[w_ch] <= 1'b0;
`ifdef HYPER_REG_IF_TWD_EN
          5'd10: r_ext_act[w_ch]  <= cfg_data_i[0];
          5'd11: r_ext_cnt[w_ch]  <= cfg_data_i[TRANS_SIZE-1:0];
          5'd12: r_ext_str[w_ch]  <= cfg_data_i[TRANS_SIZE-1:0];
          5'd13: r_l2_act[w_ch]   <= cfg_data_i[0];
          5'd14: r_l2_cnt[w_ch]   <= cfg_data_i[TRANS_SIZE-1:0];
          5'd15: r_l2_str[w_ch]   <= cfg_data_i[TRANS_SIZE-1:0];
`endif
          default: ;
        endcase
      // placed after the clear so a same-cycle drop wins
      if (w_enq_req && !w_enq) r_ovf[w_ch] <= 1'b1;
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_enq) begin
        r_q[r_wr] <= w_new;
        r_wr      <= r_wr + 1'b1;
      end
      if (w_deq) r_rd <= r_rd + 1'b1;
      r_cnt <= r_cnt + (AW+1)'(w_enq) - (AW+1)'(w_deq);
    end
  end
  assign trans_valid_o      = r_cnt != '0;
  assign trans_ch_o         = w_head.ch;
  assign trans_rx_o         = w_head.rx;
  assign trans_l2_addr_o    = w_head.l2;
  assign trans_size_o       = w_head.size;
  assign trans_hyper_addr_o = w_head.haddr;
  assign trans_rw_o         = w_head.rw;
  assign trans_addr_space_o = w_head.addr_space;
  assign trans_burst_type_o = w_head.burst;
`ifdef HYPER_REG_IF_TWD_EN
  assign trans_twd_ext_act_o    = w_head.ext_act;
  assign trans_twd_l2_act_o     = w_head.l2_act;
  assign trans_twd_ext_count_o  = w_head.ext_cnt;
  assign trans_twd_ext_stride_o = w_head.ext_str;
  assign trans_twd_l2_count_o   = w_head.l2_cnt;
  assign trans_twd_l2_stride_o  = w_head.l2_str;
`else
  assign trans_twd_ext_act_o    = 1'b0;
  assign trans_twd_l2_act_o     = 1'b0;
  assign trans_twd_ext_count_o  = '0;
  assign trans_twd_ext_stride_o = '0;
  assign trans_twd_l2_count_o   = '0;
  assign trans_twd_l2_stride_o  = '0;
`endif
endmodule
